// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared UART definitions: transmit engine state encoding, parity
//           mode constants and the parity-bit helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // data_xor is the XOR-reduction of the data bits. Odd parity makes the total
  // count of ones (data + parity) odd; even parity makes it even.
  function automatic logic parity_bit(input logic data_xor, input int mode);
    logic p;
    p = 1'b0;
    if (mode == PARITY_ODD) begin
      p = ~data_xor;
    end else if (mode == PARITY_EVEN) begin
      p = data_xor;
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_detect.sv
`default_nettype none
// ============================================================================
// Module  : baud_tick_detect
// Purpose : Rising-edge detector for the clk-synchronous baud level signal.
//           Produces a single-cycle tick per baud period.
// Ports   : clk      in  system clock
//           rst_n    in  asynchronous active-low reset
//           baud_clk in  baud level from baudrate_gen
//           tick     out 1-cycle pulse on each baud_clk rising edge
// Revision: 1.0 - initial release
// ============================================================================
module baud_tick_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic baud_clk,
  output logic tick
);

  logic baud_d;

  // Resetting the delayed copy high means a baud_clk that is already high at
  // reset release is not mistaken for a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_d <= 1'b1;
    end else begin
      baud_d <= baud_clk;
    end
  end

  assign tick = baud_clk & ~baud_d;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx
// Purpose : UART transmitter. Serialises DATA_BITS-wide words LSB first with
//           optional parity and 1 or 2 stop bits. A one-entry holding register
//           lets consecutive frames leave with no idle gap.
// Ports   : clk       in  system clock
//           rst_n     in  asynchronous active-low reset
//           baud_clk  in  baud level; rising edge marks a bit boundary
//           tx_data   in  word to send, sampled on tx_valid && tx_ready
//           tx_valid  in  source presents tx_data
//           tx_ready  out holding register empty
//           tx        out registered serial line, idle high
//           tx_busy   out engine not idle
//           tx_done   out 1-cycle pulse at the end of the last stop bit
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int                CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  state_t                 state, state_next;
  logic [DATA_BITS-1:0]   hold_data, hold_data_next;
  logic                   hold_full, hold_full_next;
  logic [DATA_BITS-1:0]   shreg, shreg_next;
  logic                   par, par_next;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_next;
  logic                   stop_cnt, stop_cnt_next;
  logic                   tx_next;
  logic                   tx_done_next;
  logic                   load;
  logic                   tick;

  baud_tick_detect u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_clk (baud_clk),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_data <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      par       <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_next;
      hold_data <= hold_data_next;
      hold_full <= hold_full_next;
      shreg     <= shreg_next;
      par       <= par_next;
      bit_cnt   <= bit_cnt_next;
      stop_cnt  <= stop_cnt_next;
      tx        <= tx_next;
      tx_done   <= tx_done_next;
    end
  end

  always_comb begin
    state_next     = state;
    hold_data_next = hold_data;
    hold_full_next = hold_full;
    shreg_next     = shreg;
    par_next       = par;
    bit_cnt_next   = bit_cnt;
    stop_cnt_next  = stop_cnt;
    tx_next        = tx;
    tx_done_next   = 1'b0;
    load           = 1'b0;

    // Accept only into an empty holding register. An unload needs a full
    // register, so accept and unload are mutually exclusive.
    if (tx_valid && !hold_full) begin
      hold_data_next = tx_data;
      hold_full_next = 1'b1;
    end

    if (tick) begin
      unique case (state)
        ST_IDLE: begin
          tx_next = 1'b1;
          load    = hold_full;
        end
        ST_START: begin
          tx_next      = shreg[0];
          bit_cnt_next = '0;
          state_next   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY != PARITY_NONE) begin
              tx_next    = par;
              state_next = ST_PARITY;
            end else begin
              tx_next       = 1'b1;
              stop_cnt_next = 1'b0;
              state_next    = ST_STOP;
            end
          end else begin
            // shreg[0] is on the line; bit 1 is the next one out.
            shreg_next   = shreg >> 1;
            tx_next      = shreg[1];
            bit_cnt_next = bit_cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          tx_next       = 1'b1;
          stop_cnt_next = 1'b0;
          state_next    = ST_STOP;
        end
        ST_STOP: begin
          if (stop_cnt == LAST_STOP) begin
            tx_done_next = 1'b1;
            state_next   = ST_IDLE;
            // A waiting word starts right away, so its start bit directly
            // follows this stop bit.
            load         = hold_full;
          end else begin
            stop_cnt_next = stop_cnt + 1'b1;
          end
        end
        default: begin
          tx_next    = 1'b1;
          state_next = ST_IDLE;
        end
      endcase

      if (load) begin
        shreg_next     = hold_data;
        par_next       = parity_bit(^hold_data, PARITY);
        hold_full_next = 1'b0;
        tx_next        = 1'b0;
        state_next     = ST_START;
      end
    end
  end

  assign tx_ready = ~hold_full;
  assign tx_busy  = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_uart_tx
// Purpose : Self-checking bench for uart_tx. Four instances cover 8N1, 8E1,
//           8O1 and 8N2. Line levels are compared, bit by bit at mid-period,
//           with a frame model built from the framing rules.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int N    = 4;
  localparam int BAUD = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           baud_clk = 1'b0;
  logic [7:0]     tx_data [N];
  logic [N-1:0]   tx_valid;
  logic [N-1:0]   tx_ready;
  logic [N-1:0]   tx;
  logic [N-1:0]   tx_busy;
  logic [N-1:0]   tx_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_g = -1;
  int bcnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Free-running baud level: 16-cycle period, 50% duty, changed on negedge.
  always @(negedge clk) begin
    bcnt     <= (bcnt + 1) % BAUD;
    baud_clk <= (((bcnt + 1) % BAUD) < (BAUD / 2));
  end

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_data(tx_data[0]),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx(tx[0]),
    .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_data(tx_data[1]),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx(tx[1]),
    .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_data(tx_data[2]),
    .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .tx(tx[2]),
    .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_data(tx_data[3]),
    .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]), .tx(tx[3]),
    .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

  // ---------------- reference model ----------------
  function automatic int par_mode(input int idx);
    return (idx == 1) ? 2 : (idx == 2) ? 1 : 0;
  endfunction

  function automatic int stop_bits(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int idx);
    return 1 + 8 + ((par_mode(idx) != 0) ? 1 : 0) + stop_bits(idx);
  endfunction

  // Level of frame bit k: start, 8 data bits LSB first, parity, stop bits.
  function automatic logic model_bit(input int idx, input logic [7:0] d, input int k);
    int ones;
    ones = $countones(d);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (par_mode(idx) != 0 && k == 9)
      return (par_mode(idx) == 2) ? logic'(ones % 2 == 1) : logic'(ones % 2 == 0);
    return 1'b1;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Leaves valid low one cycle after the accept.
  task automatic send(input int idx, input logic [7:0] d);
    int n;
    n = 0;
    tx_valid[idx] = 1'b1;
    tx_data[idx]  = d;
    while (tx_ready[idx] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("send_ready%0d", idx), tx_ready[idx], 1);
    @(negedge clk);
    tx_valid[idx] = 1'b0;
  endtask

  // Called at a negedge. Finds the start bit, checks every bit mid-period,
  // and returns on the negedge where tx_done must be high.
  task automatic check_frame(input int idx, input logic [7:0] d, input string tag);
    int n;
    int t0;
    int len;
    n   = 0;
    len = frame_len(idx);
    while (tx[idx] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, tx[idx], 0);
    if (tx[idx] !== 1'b0) return;
    t0      = cyc;
    start_g = t0;
    for (int k = 0; k < len; k++) begin
      while (cyc < t0 + BAUD * k + BAUD / 2) @(negedge clk);
      chk($sformatf("%s_bit%0d", tag, k), tx[idx], model_bit(idx, d, k));
      chk($sformatf("%s_busy%0d", tag, k), tx_busy[idx], 1);
      chk($sformatf("%s_ndone%0d", tag, k), tx_done[idx], 0);
    end
    while (cyc < t0 + BAUD * len - 1) @(negedge clk);
    chk({tag, "_done_early"}, tx_done[idx], 0);
    @(negedge clk);
    chk({tag, "_done"}, tx_done[idx], 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1;
    int s2;
    int t0;
    int n;
    int idx;
    logic [7:0] d;
    logic bad;

    tx_valid = '0;
    for (int i = 0; i < N; i++) tx_data[i] = 8'h00;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_tx", tx, 4'hF);
    chk("rst_ready", tx_ready, 4'hF);
    chk("rst_busy", tx_busy, 4'h0);
    chk("rst_done", tx_done, 4'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: 8N1 0x55
    fork
      send(0, 8'h55);
      check_frame(0, 8'h55, "t1");
    join
    chk("t1_idle_busy", tx_busy[0], 0);
    chk("t1_idle_tx", tx[0], 1);
    @(negedge clk);
    chk("t1_done_pulse", tx_done[0], 0);

    // 2: back-to-back, no gap
    fork
      begin send(0, 8'hA5); send(0, 8'h3C); end
      begin
        check_frame(0, 8'hA5, "t2a"); s1 = start_g;
        check_frame(0, 8'h3C, "t2b"); s2 = start_g;
      end
    join
    chk("t2_gap", s2 - s1, BAUD * frame_len(0));

    // 3: even and odd parity on 0x07
    fork
      send(1, 8'h07);
      check_frame(1, 8'h07, "t3e");
    join
    fork
      send(2, 8'h07);
      check_frame(2, 8'h07, "t3o");
    join

    // 4: two stop bits on 0xFF
    fork
      send(3, 8'hFF);
      check_frame(3, 8'hFF, "t4");
    join
    chk("t4_ready", tx_ready[3], 1);
    chk("t4_busy", tx_busy[3], 0);

    // 5: asynchronous reset during data bit 3
    send(0, 8'h00);
    n = 0;
    while (tx[0] !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    t0 = cyc;
    while (cyc < t0 + BAUD * 4 + BAUD / 2) @(negedge clk);
    chk("t5_pre_tx", tx[0], 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", tx[0], 1);
    chk("t5_rst_ready", tx_ready[0], 1);
    chk("t5_rst_busy", tx_busy[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (tx_done[0] !== 1'b0 || tx[0] !== 1'b1 || tx_busy[0] !== 1'b0) bad = 1'b1;
    end
    chk("t5_quiet", bad, 0);
    chk("t5_ready", tx_ready[0], 1);
    fork
      send(0, 8'hC3);
      check_frame(0, 8'hC3, "t5n");
    join

    // 6: accept on the final stop tick -> one idle bit period
    start_g = -1;
    fork
      begin
        check_frame(0, 8'h96, "t6a"); s1 = start_g;
        check_frame(0, 8'h2B, "t6b"); s2 = start_g;
      end
      begin
        send(0, 8'h96);
        n = 0;
        while (start_g < 0 && n < 200) begin @(negedge clk); n++; end
        while (start_g >= 0 && cyc < start_g + BAUD * frame_len(0) - 1) @(negedge clk);
        chk("t6_ready", tx_ready[0], 1);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h2B;
        @(negedge clk);
        tx_valid[0] = 1'b0;
      end
    join
    chk("t6_gap", s2 - s1, BAUD * frame_len(0) + BAUD);

    // Random frames across all configurations
    for (int r = 0; r < 6; r++) begin
      idx = int'($urandom_range(0, N - 1));
      d   = 8'($urandom);
      fork
        send(idx, d);
        check_frame(idx, d, $sformatf("rnd%0d", r));
      join
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
